// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit.
// Size codes, FSM states and the request bundle latched at acceptance.
package lsu_pkg;

  localparam int MEM_BYTES_DEF = 64;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MERGE,
    S_WRITE,
    S_RESP
  } lsu_state_t;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [1:0]  off;
    logic [15:0] wdata;
  } lsu_req_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane extract with sign/zero extension and lane merge.
// Purely combinational; offset 0 is the most significant byte.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [15:0] wdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] ext,
  output logic [31:0] merged
);

  logic [4:0]  bsh;
  logic [4:0]  hsh;
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    bsh    = {~off, 3'b000};
    hsh    = off[1] ? 5'd0 : 5'd16;
    b      = 8'(rd_word >> bsh);
    h      = 16'(rd_word >> hsh);
    ext    = rd_word;
    merged = rd_word;
    unique case (1'b1)
      size == SZ_BYTE: begin
        ext    = {{24{sign_ext & b[7]}}, b};
        merged = (rd_word & ~(32'h0000_00ff << bsh))
               | ({24'd0, wdata[7:0]} << bsh);
      end
      size == SZ_HALF: begin
        ext    = {{16{sign_ext & h[15]}}, h};
        merged = (rd_word & ~(32'h0000_ffff << hsh))
               | ({16'd0, wdata} << hsh);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store controller for the big-endian word memory.
// Sub-word stores do a read-modify-write of the containing word.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = MEM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  lsu_state_t  state;
  lsu_req_t    q;
  logic        bad;
  logic [32:0] last_byte;
  logic [31:0] ext;
  logic [31:0] merged;

  // Computed wide so high addresses cannot wrap into range.
  assign last_byte = {1'b0, addr[31:2], 2'b00} + 33'd3;

  always_comb begin
    bad = 1'b0;
    unique case (1'b1)
      size == SZ_BYTE: bad = 1'b0;
      size == SZ_HALF: bad = addr[0];
      size == SZ_WORD: bad = addr[1:0] != 2'b00;
      default:         bad = 1'b1;
    endcase
    if (last_byte >= 33'(MEM_BYTES)) bad = 1'b1;
  end

  lsu_lane_align u_align (
    .rd_word  (mem_read_data),
    .wdata    (q.wdata),
    .off      (q.off),
    .size     (q.size),
    .sign_ext (q.sign_ext),
    .ext      (ext),
    .merged   (merged)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      q              <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
      rdata          <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            q    <= '{we, size, sign_ext, addr[1:0], wdata[15:0]};
            busy <= 1'b1;
            if (bad) begin
              state <= S_RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else if (we && size == SZ_WORD) begin
              state          <= S_WRITE;
              mem_write      <= 1'b1;
              mem_address    <= {addr[31:2], 2'b00};
              mem_write_data <= wdata;
            end else begin
              state       <= S_READ;
              mem_read    <= 1'b1;
              mem_address <= {addr[31:2], 2'b00};
            end
          end
        end
        S_READ: begin
          mem_read <= 1'b0;
          state    <= S_MERGE;
        end
        S_MERGE: begin
          if (q.we) begin
            mem_write_data <= merged;
            mem_write      <= 1'b1;
            state          <= S_WRITE;
          end else begin
            rdata <= ext;
            done  <= 1'b1;
            state <= S_RESP;
          end
        end
        S_WRITE: begin
          mem_write      <= 1'b0;
          mem_write_data <= '0;
          done           <= 1'b1;
          state          <= S_RESP;
        end
        S_RESP: begin
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-array memory model.
// Expected results queue at issue and are checked at done.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        sign_ext = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err;
  logic [31:0] rdata, mem_address, mem_write_data;
  logic        mem_write, mem_read;
  logic [31:0] mem_read_data = '0;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(64)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req            (req),
    .we             (we),
    .size           (size),
    .sign_ext       (sign_ext),
    .addr           (addr),
    .wdata          (wdata),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .rdata          (rdata),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  logic [7:0] mem [64] = '{default: 8'h00};
  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int ovl_cnt = 0;

  always @(posedge clk) begin
    logic [5:0] a;
    a = {mem_address[5:2], 2'b00};
    if (mem_write) begin
      mem[a]     <= mem_write_data[31:24];
      mem[a + 1] <= mem_write_data[23:16];
      mem[a + 2] <= mem_write_data[15:8];
      mem[a + 3] <= mem_write_data[7:0];
      wr_cnt <= wr_cnt + 1;
    end
    if (mem_read) begin
      mem_read_data <= {mem[a], mem[a + 1], mem[a + 2], mem[a + 3]};
      rd_cnt <= rd_cnt + 1;
    end
    if (mem_read && mem_write) ovl_cnt <= ovl_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  exp_t sbq[$];
  int ncmp = 0;
  int nfail = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic access(string tag, logic w, logic [1:0] sz,
                        logic sx, logic [31:0] a, logic [31:0] d,
                        logic e_err, logic [31:0] e_rd, int e_lat,
                        int e_nr, int e_nw, logic hold);
    exp_t x;
    int lat, r0, w0, d0;
    x = '{e_rd, e_err, e_lat, e_nr, e_nw};
    sbq.push_back(x);
    @(negedge clk);
    r0 = rd_cnt;
    w0 = wr_cnt;
    d0 = done_cnt;
    we = w;
    size = sz;
    sign_ext = sx;
    addr = a;
    wdata = d;
    req = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
    check({tag, ".busy_acc"}, 32'(busy), 32'd1);
    lat = 1;
    while (done !== 1'b1 && lat < 16) begin
      @(posedge clk);
      #1;
      lat++;
    end
    req = 1'b0;
    x = sbq.pop_front();
    check({tag, ".latency"}, 32'(lat), 32'(x.lat));
    check({tag, ".err"}, 32'(err), 32'(x.err));
    check({tag, ".rdata"}, rdata, x.rdata);
    @(posedge clk);
    #1;
    check({tag, ".idle"}, {30'd0, busy, done}, 32'd0);
    @(posedge clk);
    #1;
    check({tag, ".nread"}, 32'(rd_cnt - r0), 32'(x.nrd));
    check({tag, ".nwrite"}, 32'(wr_cnt - w0), 32'(x.nwr));
    check({tag, ".ndone"}, 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, ".flags"},
          {27'd0, busy, done, err, mem_read, mem_write}, 32'd0);
    check({tag, ".rdata"}, rdata, 32'd0);
    check({tag, ".maddr"}, mem_address, 32'd0);
    check({tag, ".mwdata"}, mem_write_data, 32'd0);
  endtask

  initial begin
    int w0, d0;
    #1;
    check_reset_outs("por");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    access("st_w8", 1, SZ_WORD, 0, 32'h08, 32'hA1B2C3D4,
           0, 32'h0, 2, 0, 1, 0);
    access("ld_w8", 0, SZ_WORD, 0, 32'h08, 32'h0,
           0, 32'hA1B2C3D4, 3, 1, 0, 0);
    access("ld_b9s", 0, SZ_BYTE, 1, 32'h09, 32'h0,
           0, 32'hFFFFFFB2, 3, 1, 0, 0);
    access("ld_b9u", 0, SZ_BYTE, 0, 32'h09, 32'h0,
           0, 32'h000000B2, 3, 1, 0, 0);
    access("ld_bBu", 0, SZ_BYTE, 0, 32'h0B, 32'h0,
           0, 32'h000000D4, 3, 1, 0, 0);
    access("ld_h8s", 0, SZ_HALF, 1, 32'h08, 32'h0,
           0, 32'hFFFFA1B2, 3, 1, 0, 0);
    access("st_hA", 1, SZ_HALF, 0, 32'h0A, 32'h00001234,
           0, 32'hFFFFA1B2, 4, 1, 1, 0);
    access("ld_w8b", 0, SZ_WORD, 0, 32'h08, 32'h0,
           0, 32'hA1B21234, 3, 1, 0, 0);
    access("st_b8", 1, SZ_BYTE, 0, 32'h08, 32'h0000007E,
           0, 32'hA1B21234, 4, 1, 1, 0);
    access("ld_hold", 0, SZ_WORD, 0, 32'h08, 32'h0,
           0, 32'h7EB21234, 3, 1, 0, 1);
    access("err_h3", 0, SZ_HALF, 0, 32'h03, 32'h0,
           1, 32'h7EB21234, 1, 0, 0, 0);
    access("err_w40", 0, SZ_WORD, 0, 32'h40, 32'h0,
           1, 32'h7EB21234, 1, 0, 0, 0);
    access("err_sz3", 0, 2'b11, 0, 32'h00, 32'h0,
           1, 32'h7EB21234, 1, 0, 0, 0);
    access("err_st_hi", 1, SZ_WORD, 0, 32'h8000_0008, 32'h1,
           1, 32'h7EB21234, 1, 0, 0, 0);
    access("ld_last", 0, SZ_BYTE, 0, 32'h3F, 32'h0,
           0, 32'h0, 3, 1, 0, 0);

    @(negedge clk);
    we = 1'b1;
    size = SZ_BYTE;
    sign_ext = 1'b0;
    addr = 32'h08;
    wdata = 32'h00000055;
    req = 1'b1;
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #1;
    w0 = wr_cnt;
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check_reset_outs("rst_mid");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_mid.nwrite", 32'(wr_cnt - w0), 32'd0);
    check("rst_mid.ndone", 32'(done_cnt - d0), 32'd0);
    check("rst_mid.mem8", {mem[8], mem[9], mem[10], mem[11]},
          32'h7EB21234);
    access("ld_after_rst", 0, SZ_WORD, 0, 32'h08, 32'h0,
           0, 32'h7EB21234, 3, 1, 0, 0);
    check("strobe_overlap", 32'(ovl_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
